// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and playfield geometry used by the
// timing generator, grid mapper and colour mapper.
package vga_pkg;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;

    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;

    localparam int unsigned VGA_CLK_DIV   = 2;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync windows are half-open: [START, END).
    localparam int unsigned VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int unsigned VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    localparam int unsigned BLOCK_SIZE     = 20;
    localparam int unsigned FIELD_X_MIN    = 320;
    localparam int unsigned FIELD_X_MAX    = 520;
    localparam int unsigned FIELD_Y_BOTTOM = 440;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, DrawX/DrawY counters and registered
// hs/vs/blank/frame_start decode aligned with the counters.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pixel_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pixel_en_q, pixel_en_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        div_d         = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        pixel_en_d    = (div_q == DIV_MAX);
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;

        if (pixel_en_q) begin
            if (x_q == H_MAX) begin
                x_d = '0;
                if (y_q == V_MAX) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decode from next-state counters so the registered flags line up with DrawX/DrawY.
        hs_d    = !((x_d >= HS_START) && (x_d < HS_END));
        vs_d    = !((y_d >= VS_START) && (y_d < VS_END));
        blank_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q         <= '0;
            pixel_en_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixel_en_q    <= pixel_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_en    = pixel_en_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size 640x480 instance for horizontal behaviour and a
// shrunken-geometry instance so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fs;
        logic       sync;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_full, rst_small;
    logic       f_pe, f_hs, f_vs, f_blank, f_sync, f_fs;
    logic [9:0] f_x, f_y;
    logic       s_pe, s_hs, s_vs, s_blank, s_sync, s_fs;
    logic [9:0] s_x, s_y;
    obs_t       f_obs, s_obs;

    int total = 0;
    int bad   = 0;

    assign f_obs = {f_pe, f_x, f_y, f_hs, f_vs, f_blank, f_fs, f_sync};
    assign s_obs = {s_pe, s_x, s_y, s_hs, s_vs, s_blank, s_fs, s_sync};

    vga_timing_gen dut_full (
        .Clk         (clk),
        .Reset       (rst_full),
        .pixel_en    (f_pe),
        .DrawX       (f_x),
        .DrawY       (f_y),
        .hs          (f_hs),
        .vs          (f_vs),
        .blank       (f_blank),
        .sync        (f_sync),
        .frame_start (f_fs)
    );

    // Small raster: H 8+2+3+2=15 (hs low x=10..12), V 6+1+2+1=10 (vs low y=7..8),
    // so one frame is 15*10*2 = 300 Clk cycles.
    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (2),
        .V_VISIBLE (6),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .CLK_DIV   (2)
    ) dut_small (
        .Clk         (clk),
        .Reset       (rst_small),
        .pixel_en    (s_pe),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank       (s_blank),
        .sync        (s_sync),
        .frame_start (s_fs)
    );

    // Expected outputs k cycles after the last reset edge (k=0 is the reset state).
    function automatic obs_t model(input int k, input int ht, input int vt, input int hv,
                                   input int hss, input int hse, input int vv,
                                   input int vss, input int vse);
        obs_t e;
        int   p, x, y;
        p       = (k < 1) ? 0 : (k - 1) / 2;
        x       = p % ht;
        y       = (p / ht) % vt;
        e.pe    = (k >= 1) && (k % 2 == 0);
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.hs    = !((x >= hss) && (x < hse));
        e.vs    = !((y >= vss) && (y < vse));
        e.blank = (x < hv) && (y < vv);
        e.fs    = (k >= 3) && (k % 2 == 1) && (p % (ht * vt) == 0);
        e.sync  = 1'b0;
        return e;
    endfunction

    function automatic obs_t model_full(input int k);
        return model(k, 800, 525, 640, 656, 752, 480, 490, 492);
    endfunction

    function automatic obs_t model_small(input int k);
        return model(k, 15, 10, 8, 10, 13, 6, 7, 9);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_full  = 1'b1;
        rst_small = 1'b1;
        step();
        step();
        rst_full  = 1'b0;
        rst_small = 1'b0;
        if (f_obs !== model_full(0)) begin
            bad++;
            $display("FAIL reset_full got=%h want=%h", f_obs, model_full(0));
        end
        total++;
        if (s_obs !== model_small(0)) begin
            bad++;
            $display("FAIL reset_small got=%h want=%h", s_obs, model_small(0));
        end
        total++;
    endtask

    task automatic test_startup();
        obs_t e;
        rst_full = 1'b1;
        step();
        rst_full = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            e = model_full(k);
            if (f_obs !== e) begin
                bad++;
                $display("FAIL startup k=%0d got=%h want=%h", k, f_obs, e);
            end
            total++;
        end
    endtask

    // First line and the start of the second: hs window, blank edge, line wrap.
    task automatic test_hline();
        obs_t e;
        rst_full = 1'b1;
        step();
        rst_full = 1'b0;
        for (int k = 1; k <= 1700; k++) begin
            step();
            e = model_full(k);
            if (f_obs !== e) begin
                bad++;
                $display("FAIL hline k=%0d got=%h want=%h", k, f_obs, e);
            end
            total++;
        end
    endtask

    task automatic test_frame_small();
        obs_t e;
        int   pulses  = 0;
        int   first_k = -1;
        int   next_k  = -1;
        int   vs_low  = 0;
        rst_small = 1'b1;
        step();
        rst_small = 1'b0;
        for (int k = 1; k <= 650; k++) begin
            step();
            e = model_small(k);
            if (s_obs !== e) begin
                bad++;
                $display("FAIL frame k=%0d got=%h want=%h", k, s_obs, e);
            end
            total++;
            if (s_fs === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                else if (next_k < 0) next_k = k;
            end
            if (k <= 300 && s_vs === 1'b0) vs_low++;
        end
        if (pulses != 2) begin
            bad++;
            $display("FAIL frame_pulse_count got=%0d want=2", pulses);
        end
        total++;
        if (first_k != 301) begin
            bad++;
            $display("FAIL frame_first_pulse got=%0d want=301", first_k);
        end
        total++;
        if (next_k - first_k != 300) begin
            bad++;
            $display("FAIL frame_period got=%0d want=300", next_k - first_k);
        end
        total++;
        if (vs_low != 60) begin
            bad++;
            $display("FAIL vs_low_cycles got=%0d want=60", vs_low);
        end
        total++;
    endtask

    task automatic test_mid_reset();
        obs_t e;
        rst_small = 1'b1;
        step();
        rst_small = 1'b0;
        for (int k = 1; k <= 131; k++) step();
        e = model_small(131);
        if (s_obs !== e) begin
            bad++;
            $display("FAIL mid_position got=%h want=%h", s_obs, e);
        end
        total++;
        rst_small = 1'b1;
        step();
        rst_small = 1'b0;
        if (s_obs !== model_small(0)) begin
            bad++;
            $display("FAIL mid_reset got=%h want=%h", s_obs, model_small(0));
        end
        total++;
        for (int k = 1; k <= 320; k++) begin
            step();
            e = model_small(k);
            if (s_obs !== e) begin
                bad++;
                $display("FAIL mid_rerun k=%0d got=%h want=%h", k, s_obs, e);
            end
            total++;
        end
    endtask

    initial begin
        rst_full  = 1'b1;
        rst_small = 1'b1;
        test_reset();
        test_startup();
        test_hline();
        test_frame_small();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
